// File: rtl/a_wb_ctrl.sv
// rtl/a_wb_ctrl.sv - A-register write-back controller: reservation scoreboard, two result buses, collision FIFO
// Optional result-to-unreserved-register check is enabled by defining A_WB_ERRCHK_EN.
module a_wb_ctrl #(
   parameter int WIDTH      = 24,
   parameter int LOGDEPTH   = 3,
   parameter int DEPTH      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_rsv_en,
   input  logic [LOGDEPTH-1:0] i_rsv_addr,
   input  logic                i_fu0_vld,
   input  logic [LOGDEPTH-1:0] i_fu0_addr,
   input  logic [WIDTH-1:0]    i_fu0_data,
   input  logic                i_fu1_vld,
   input  logic [LOGDEPTH-1:0] i_fu1_addr,
   input  logic [WIDTH-1:0]    i_fu1_data,
   output logic                o_wr_en,
   output logic [LOGDEPTH-1:0] o_wr_addr,
   output logic [WIDTH-1:0]    o_wr_data,
   output logic [DEPTH-1:0]    o_busy,
   output logic                o_stall,
   output logic                o_ovf,
   output logic                o_err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [LOGDEPTH-1:0] fa_q [FIFO_DEPTH];
   logic [WIDTH-1:0]    fd_q [FIFO_DEPTH];
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d, room;
   logic                wr_en_q, wr_en_d;
   logic [LOGDEPTH-1:0] wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]    wr_data_q, wr_data_d;
   logic [DEPTH-1:0]    busy_q, busy_d;
   logic                ovf_q, ovf_d;
   logic                pop, p0_vld, p1_vld, acc0, acc1;
   logic [LOGDEPTH-1:0] p0_addr, p1_addr;
   logic [WIDTH-1:0]    p0_data, p1_data;

   // p0/p1 are the incoming results left over after write selection, compacted in fu0-first order.
   always_comb begin
      pop       = (cnt_q != '0);
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      p0_vld    = 1'b0;
      p0_addr   = i_fu0_addr;
      p0_data   = i_fu0_data;
      p1_vld    = 1'b0;
      p1_addr   = i_fu1_addr;
      p1_data   = i_fu1_data;
      if (pop) begin
         wr_en_d   = 1'b1;
         wr_addr_d = fa_q[rd_ptr_q];
         wr_data_d = fd_q[rd_ptr_q];
         if (i_fu0_vld) begin
            p0_vld = 1'b1;
            p1_vld = i_fu1_vld;
         end else begin
            p0_vld  = i_fu1_vld;
            p0_addr = i_fu1_addr;
            p0_data = i_fu1_data;
         end
      end else if (i_fu0_vld) begin
         wr_en_d   = 1'b1;
         wr_addr_d = i_fu0_addr;
         wr_data_d = i_fu0_data;
         p0_vld    = i_fu1_vld;
         p0_addr   = i_fu1_addr;
         p0_data   = i_fu1_data;
      end else if (i_fu1_vld) begin
         wr_en_d   = 1'b1;
         wr_addr_d = i_fu1_addr;
         wr_data_d = i_fu1_data;
      end

      // The head leaving on this edge frees its slot for an incoming push.
      room     = CW'(FIFO_DEPTH) - cnt_q + CW'(pop);
      acc0     = p0_vld && (room != '0);
      acc1     = p1_vld && (room >= CW'(2));
      ovf_d    = ovf_q | (p0_vld & ~acc0) | (p1_vld & ~acc1);
      cnt_d    = cnt_q - CW'(pop) + CW'(acc0) + CW'(acc1);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(acc0) + PW'(acc1);

      busy_d = busy_q;
      if (wr_en_d) busy_d[wr_addr_d] = 1'b0;
      if (i_rsv_en) busy_d[i_rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (acc0) begin
         fa_q[wr_ptr_q] <= p0_addr;
         fd_q[wr_ptr_q] <= p0_data;
      end
      if (acc1) begin
         fa_q[wr_ptr_q + PW'(1)] <= p1_addr;
         fd_q[wr_ptr_q + PW'(1)] <= p1_data;
      end
   end

`ifdef A_WB_ERRCHK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q
            | (wr_en_d && !pop && !busy_q[wr_addr_d])
            | (acc0 && !busy_q[p0_addr])
            | (acc1 && !busy_q[p1_addr]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

   assign o_wr_en   = wr_en_q;
   assign o_wr_addr = wr_addr_q;
   assign o_wr_data = wr_data_q;
   assign o_busy    = busy_q;
   assign o_ovf     = ovf_q;
   assign o_stall   = (cnt_q > CW'(FIFO_DEPTH - 2));
endmodule

// File: doc/a_wb_ctrl.md
# a_wb_ctrl

Write-back controller for the 8-entry, 24-bit address register file. It is the write-side counterpart of the register file. It keeps a reservation scoreboard of pending A-register destinations and accepts results from two functional-unit result buses. It serializes those results through a small collision FIFO and drives the register file's single write port, one write per cycle, in arrival order.

## Interface
- WIDTH, 24, data width of an A register
- LOGDEPTH, 3, register address width
- DEPTH, 8, number of A registers (scoreboard bits)
- FIFO_DEPTH, 4, collision FIFO entries (power of two, >= 2)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low; clears scoreboard, FIFO, outputs
- i_rsv_en  input  1  issue reserves a destination this cycle
- i_rsv_addr  input  LOGDEPTH  destination being reserved
- i_fu0_vld  input  1  result valid, bus 0 (address add/multiply)
- i_fu0_addr  input  LOGDEPTH  bus 0 destination
- i_fu0_data  input  WIDTH  bus 0 result
- i_fu1_vld  input  1  result valid, bus 1 (memory load / S-to-A transfer)
- i_fu1_addr  input  LOGDEPTH  bus 1 destination
- i_fu1_data  input  WIDTH  bus 1 result
- o_wr_en  output  1  register file write enable
- o_wr_addr  output  LOGDEPTH  register file write address
- o_wr_data  output  WIDTH  register file write data
- o_busy  output  DEPTH  reservation bit per register
- o_stall  output  1  issue must hold; fewer than 2 FIFO slots free
- o_ovf  output  1  sticky: a result was dropped on FIFO overflow
- o_err  output  1  sticky: result arrived for an unreserved register (see Configuration)

## Operation
- Reset values:
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0
  - o_busy=0, o_ovf=0, o_err=0
  - FIFO empty, so o_stall=0
- Each cycle, the incoming results are ordered fu0 first, then fu1. The head FIFO entry, if any, precedes both.
- Write selection:
  - FIFO non-empty: pop the head into o_wr_*. All valid incoming results are pushed, fu0 first.
  - FIFO empty, one result valid: that result goes directly to o_wr_*.
  - FIFO empty, both valid: fu0 goes to o_wr_*; fu1 is pushed.
  - Nothing pending: o_wr_en=0. o_wr_addr and o_wr_data hold their last values.
- Simultaneous pop and push on the same cycle is legal. Count changes by pushes minus pops.
- Overflow:
  - A push that finds the FIFO full is dropped and sets o_ovf.
  - With two pushes, fu0 is accepted if room exists and fu1 is dropped.
  - Issue honouring o_stall never overflows.
- Scoreboard:
  - i_rsv_en sets busy[i_rsv_addr].
  - A write issued on o_wr_* clears busy[o_wr_addr] on the same edge that o_wr_en goes high.
  - If a set and a clear target the same register on the same edge, the set wins.
  - Reserving an already-busy register is legal; the bit stays set.
- Register 0 is written like any other register. Zero/one substitution on read is the register file's concern.
- Asserting rst mid-operation discards FIFO contents and in-flight results immediately; no partial write is emitted.

## Timing
- Latency from result valid to o_wr_en: 1 cycle with an empty FIFO, 1 + N cycles with N entries ahead.
- Throughput is exactly one write per cycle while anything is pending.
- o_wr_*, o_busy, o_ovf and o_err are registered.
- o_stall is combinational from the FIFO count register only: o_stall = (count > FIFO_DEPTH-2).
- o_busy reflects a reservation one cycle after i_rsv_en.
- Consumers see a result in the register file through its write bypass in the o_wr_en cycle. From the next cycle it is in storage.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is LOG2(FIFO_DEPTH)+1 bits.

## Configuration
- A_WB_ERRCHK_EN defined:
  - o_err is set when a result is accepted (direct or pushed) whose destination busy bit is 0 at that edge.
  - o_err is cleared only by rst.
- Undefined: o_err is tied to 0 and no check logic is built.
- Everything else is identical in both builds.

## Test plan
- Reset, then i_rsv_en addr 3 -> o_busy=0x08 next cycle. Then fu0 vld addr 3 data 0x123456 -> next cycle o_wr_en=1, addr 3, data 0x123456, o_busy=0x00.
- fu0 (addr 1, 0xA) and fu1 (addr 2, 0xB) valid in the same cycle -> writes addr 1 then addr 2 on consecutive cycles; FIFO empty afterwards.
- Drive both buses valid every cycle for 3 cycles -> o_stall rises when count=3. Writes emerge in order fu0,fu1,fu0,... with no gaps. With continued injection, the first dropped result sets o_ovf=1.
- i_rsv_en addr 5 on the same edge o_wr_en writes addr 5 -> o_busy[5]=1 afterwards.
- Assert rst low asynchronously with 3 FIFO entries pending -> all outputs 0 immediately. After release, no stale writes appear.
- With A_WB_ERRCHK_EN, fu1 result to unreserved addr 6 -> o_err=1 and it stays set. Without the macro -> o_err stays 0.
